entropy_symbol_scheduler: RTL
=============================

# entropy_symbol_scheduler

Sequences the symbol stream into the parallel entropy encoder. Accepts one symbol per cycle (CDF or Boolean) over a valid/ready handshake, packs runs of up to three consecutive Boolean symbols into a single encoder word on lanes 1–3, and issues CDF symbols alone on lane 1. It owns the encoder's frame control: the `flag_first` marking, the `final_flag` drain, waiting for `OUT_FLAG_LAST`, and the one-cycle encoder reset between frames. It sits between the symbol source and `entropy_encoder`, whose clock enable is driven by `enc_valid`.

## Interface
- `RANGE_WIDTH`, default 16: width of `fl` and `fh`.
- `SYMBOL_WIDTH`, default 4: width of a symbol; `nsyms` is `SYMBOL_WIDTH+1` bits.
- `top_clk`, input, 1: clock. All logic is rising-edge.
- `top_reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an upstream symbol is present.
- `in_ready`, output, 1: the scheduler accepts the symbol this cycle.
- `in_bool`, input, 1: symbol type. 1 = CDF, 0 = Boolean.
- `in_fl` / `in_fh`, input, `RANGE_WIDTH`: CDF bounds (or the probability, for Boolean symbols).
- `in_symbol`, input, `SYMBOL_WIDTH`: symbol value; bit 0 only for Boolean symbols.
- `in_nsyms`, input, `SYMBOL_WIDTH+1`: alphabet size.
- `in_last`, input, 1: last symbol of the frame.
- `enc_valid`, output, 1: the `enc_*` word is valid this cycle (encoder clock enable).
- `enc_reset`, output, 1: active-high encoder reset pulse.
- `enc_flag_first`, output, 1: first word of a frame.
- `enc_final_flag`, output, 1: frame drain request.
- `enc_fl` / `enc_fh`, output, `RANGE_WIDTH`: taken from the lane-1 symbol.
- `enc_nsyms`, output, `SYMBOL_WIDTH+1`: taken from the lane-1 symbol.
- `enc_symbol_1..3`, output, `SYMBOL_WIDTH` each: lane symbols.
- `enc_bool_1..3`, output, 1 each: lane type. 0 = Boolean; 1 = CDF or idle.
- `enc_flag_last`, input, 1: the encoder's `OUT_FLAG_LAST`.
- `busy`, output, 1: the FSM is not in RUN, or the gather or hold register is non-empty.

## Operation
- **FSM states:** ENC_RST → RUN → FLUSH → ENC_RST.
  - ENC_RST lasts exactly 1 cycle: `enc_reset`=1 and `in_ready`=0. The next state is RUN, with `first_pend`=1.
  - RUN:
    - `in_ready` = !`hold_full` && !`last_pend`.
    - Symbols are gathered into G, which holds up to 2 Booleans with count `g`.
    - A 1-entry hold register H holds a deferred CDF symbol.
  - FLUSH: `enc_final_flag`=1 and `in_ready`=0. The state moves to ENC_RST in the cycle after `enc_flag_last` is sampled high.
- **Issue rules in RUN (at most one word per cycle):**
  - If H is full: issue H as a CDF word and clear H. No accept occurs, because `in_ready`=0.
  - Accepted CDF with `g`=0: issue the CDF word.
  - Accepted CDF with `g`>0: issue G as a Boolean word and load the CDF into H.
  - Accepted Boolean:
    - If `g`=2, or `in_last`=1: issue G plus the new symbol.
    - Otherwise: append the symbol to G.
  - No accept and `g`>0: issue G as a partial word. G is never held across an upstream bubble.
- **Word format:**
  - Lanes fill in order 1, 2, 3.
  - Unused lanes: `enc_bool_k`=1, `enc_symbol_k`=0.
  - CDF word: `enc_bool_1`=1, and `fl`/`fh`/`nsyms` come from the symbol.
- **Frame marking:**
  - `enc_flag_first`=1 only on the first issued word after ENC_RST.
  - `last_pend` is set when the last symbol is accepted.
  - Once the word carrying the last symbol has been issued, the state moves to FLUSH on the next cycle.
- **Ignored input:** `enc_flag_last` is ignored outside FLUSH.

## Timing
- **Reset values** (`top_reset`=0, asynchronous):
  - State = ENC_RST.
  - All `enc_*` outputs = 0, except `enc_bool_1..3`=1.
  - `in_ready`=0, `busy`=1.
  - G, H, `first_pend` and `last_pend` are cleared.
- **After reset release:** ENC_RST is the first state, so `enc_reset` pulses in the first clocked cycle.
- **Output registering:** all `enc_*` outputs are registered.
  - Latency from accepted symbol to `enc_valid` is 1 cycle for immediate issues.
  - The second of a deferred pair (via H) appears 2 cycles after acceptance.
  - A Boolean stays in G until its word issues (third Boolean, bubble, CDF or last).
- **Word hold:** `enc_*` data hold their values while `enc_valid`=0. `enc_final_flag` is independent of `enc_valid`.
- **Reset mid-frame:** asserting `top_reset` in any state discards G, H and the frame; no drain occurs.

## Configuration
- **`SCHED_BOOL_PACK_EN` defined:** Boolean packing operates as described above.
- **Not defined:**
  - Every symbol issues alone on lane 1, one cycle after acceptance.
  - Lanes 2 and 3 stay idle.
  - G is not instantiated and `in_ready` depends only on H/`last_pend`; H is never loaded.

## Test plan
- **Reset and first CDF:** release reset, then drive CDF `fl`=100, `fh`=200, `nsyms`=4.
  - `enc_reset` is high for 1 cycle.
  - Next, `enc_valid`=1 with `enc_flag_first`=1, `enc_fl`=100, `enc_fh`=200 and `enc_bool_1..3`=1,1,1.
- **Burst of five Booleans** (values 1,0,1,1,0, back-to-back, then a bubble):
  - Word A: `enc_bool`=0,0,0 with symbols 1,0,1.
  - Word B: `enc_bool`=0,0,1 with symbols 1,0,0.
- **Boolean then CDF, back-to-back:**
  - Boolean word with lane 1 only.
  - `in_ready`=0 for 1 cycle.
  - CDF word in the next cycle.
- **Last symbol** (Boolean with `in_last`=1 and `g`=1):
  - A 2-lane word issues.
  - FLUSH follows, with `enc_final_flag`=1 held.
  - Hold `enc_flag_last`=0 for 10 cycles, then pulse it to 1: ENC_RST follows, then a new frame with `enc_flag_first`=1.
- **Reset mid-FLUSH:** assert `top_reset` while `enc_final_flag`=1.
  - All outputs return to their reset values immediately.
  - After release, `enc_reset` pulses again.
- **`SCHED_BOOL_PACK_EN` undefined:** drive three back-to-back Booleans. Three single-lane words issue on consecutive cycles.

Source files
------------

// File: rtl/entropy_symbol_scheduler.sv
// rtl/entropy_symbol_scheduler.sv - symbol-to-encoder word scheduler with frame control (optional SCHED_BOOL_PACK_EN)
module entropy_symbol_scheduler #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4
) (
  input  logic                    top_clk,
  input  logic                    top_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_bool,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_last,
  output logic                    enc_valid,
  output logic                    enc_reset,
  output logic                    enc_flag_first,
  output logic                    enc_final_flag,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
  output logic                    enc_bool_1,
  output logic                    enc_bool_2,
  output logic                    enc_bool_3,
  input  logic                    enc_flag_last,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_ENC_RST = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t state;
  logic   first_pend;
  logic   last_pend;
  logic   accept;
  logic   drained;

  // Candidate encoder word for this cycle; registered into enc_* when w_issue is set.
  logic                         w_issue;
  logic [RANGE_WIDTH-1:0]       w_fl;
  logic [RANGE_WIDTH-1:0]       w_fh;
  logic [SYMBOL_WIDTH:0]        w_nsyms;
  logic [2:0]                   w_bool;
  logic [2:0][SYMBOL_WIDTH-1:0] w_sym;

  // Boolean symbols carry only bit 0 on the lane.
  function automatic logic [SYMBOL_WIDTH-1:0] bool_sym(input logic b);
    logic [SYMBOL_WIDTH-1:0] s;
    s    = '0;
    s[0] = b;
    return s;
  endfunction

  assign accept = in_valid && in_ready;

`ifdef SCHED_BOOL_PACK_EN
  // H: one deferred CDF symbol that lost the cycle to a pending Boolean word.
  logic                    h_full;
  logic [RANGE_WIDTH-1:0]  h_fl;
  logic [RANGE_WIDTH-1:0]  h_fh;
  logic [SYMBOL_WIDTH-1:0] h_symbol;
  logic [SYMBOL_WIDTH:0]   h_nsyms;
  logic                    h_load;

  // G: up to two gathered Booleans; lane-1 ranges come from the first one.
  logic [1:0]              g_cnt;
  logic [1:0]              g_bits;
  logic [RANGE_WIDTH-1:0]  g_fl;
  logic [RANGE_WIDTH-1:0]  g_fh;
  logic [SYMBOL_WIDTH:0]   g_nsyms;
  logic [1:0]              g_cnt_nxt;
  logic [1:0]              g_bits_nxt;
  logic [RANGE_WIDTH-1:0]  g_fl_nxt;
  logic [RANGE_WIDTH-1:0]  g_fh_nxt;
  logic [SYMBOL_WIDTH:0]   g_nsyms_nxt;

  // Lane view of G alone (stale bits beyond g_cnt are masked off).
  logic [2:0]                   gw_bool;
  logic [2:0][SYMBOL_WIDTH-1:0] gw_sym;

  assign gw_bool   = {1'b1, g_cnt != 2'd2, g_cnt == 2'd0};
  assign gw_sym[0] = (g_cnt != 2'd0) ? bool_sym(g_bits[0]) : '0;
  assign gw_sym[1] = (g_cnt == 2'd2) ? bool_sym(g_bits[1]) : '0;
  assign gw_sym[2] = '0;

  assign in_ready = (state == ST_RUN) && !h_full && !last_pend;
  assign busy     = (state != ST_RUN) || (g_cnt != 2'd0) || h_full;
  assign drained  = (g_cnt == 2'd0) && !h_full;

  // Pick at most one word per cycle and work out the next G contents.
  always_comb begin
    w_issue     = 1'b0;
    w_fl        = in_fl;
    w_fh        = in_fh;
    w_nsyms     = in_nsyms;
    w_bool      = 3'b111;
    w_sym       = '0;
    h_load      = 1'b0;
    g_cnt_nxt   = g_cnt;
    g_bits_nxt  = g_bits;
    g_fl_nxt    = g_fl;
    g_fh_nxt    = g_fh;
    g_nsyms_nxt = g_nsyms;
    if (state == ST_RUN) begin
      if (h_full) begin
        w_issue  = 1'b1;
        w_fl     = h_fl;
        w_fh     = h_fh;
        w_nsyms  = h_nsyms;
        w_sym[0] = h_symbol;
      end else if (accept && in_bool) begin
        w_issue = 1'b1;
        if (g_cnt == 2'd0) begin
          w_sym[0] = in_symbol;
        end else begin
          w_fl      = g_fl;
          w_fh      = g_fh;
          w_nsyms   = g_nsyms;
          w_bool    = gw_bool;
          w_sym     = gw_sym;
          g_cnt_nxt = 2'd0;
          h_load    = 1'b1;
        end
      end else if (accept) begin
        if ((g_cnt == 2'd2) || in_last) begin
          w_issue = 1'b1;
          w_bool  = gw_bool;
          w_sym   = gw_sym;
          if (g_cnt != 2'd0) begin
            w_fl    = g_fl;
            w_fh    = g_fh;
            w_nsyms = g_nsyms;
          end
          w_bool[g_cnt] = 1'b0;
          w_sym[g_cnt]  = bool_sym(in_symbol[0]);
          g_cnt_nxt     = 2'd0;
        end else begin
          if (g_cnt == 2'd0) begin
            g_fl_nxt    = in_fl;
            g_fh_nxt    = in_fh;
            g_nsyms_nxt = in_nsyms;
          end
          g_bits_nxt[g_cnt[0]] = in_symbol[0];
          g_cnt_nxt            = g_cnt + 2'd1;
        end
      end else if (g_cnt != 2'd0) begin
        // Upstream bubble: never sit on a partial Boolean word.
        w_issue   = 1'b1;
        w_fl      = g_fl;
        w_fh      = g_fh;
        w_nsyms   = g_nsyms;
        w_bool    = gw_bool;
        w_sym     = gw_sym;
        g_cnt_nxt = 2'd0;
      end
    end
  end
`else
  assign in_ready = (state == ST_RUN) && !last_pend;
  assign busy     = (state != ST_RUN);
  assign drained  = 1'b1;

  // Every accepted symbol goes out alone on lane 1.
  always_comb begin
    w_issue = 1'b0;
    w_fl    = in_fl;
    w_fh    = in_fh;
    w_nsyms = in_nsyms;
    w_bool  = 3'b111;
    w_sym   = '0;
    if (accept) begin
      w_issue = 1'b1;
      if (in_bool) begin
        w_sym[0] = in_symbol;
      end else begin
        w_bool[0] = 1'b0;
        w_sym[0]  = bool_sym(in_symbol[0]);
      end
    end
  end
`endif

  // Frame FSM with registered encoder outputs and gather/hold storage.
  always_ff @(posedge top_clk or negedge top_reset) begin
    if (!top_reset) begin
      state          <= ST_ENC_RST;
      first_pend     <= 1'b0;
      last_pend      <= 1'b0;
      enc_valid      <= 1'b0;
      enc_reset      <= 1'b0;
      enc_flag_first <= 1'b0;
      enc_final_flag <= 1'b0;
      enc_fl         <= '0;
      enc_fh         <= '0;
      enc_nsyms      <= '0;
      enc_symbol_1   <= '0;
      enc_symbol_2   <= '0;
      enc_symbol_3   <= '0;
      enc_bool_1     <= 1'b1;
      enc_bool_2     <= 1'b1;
      enc_bool_3     <= 1'b1;
`ifdef SCHED_BOOL_PACK_EN
      h_full         <= 1'b0;
      h_fl           <= '0;
      h_fh           <= '0;
      h_symbol       <= '0;
      h_nsyms        <= '0;
      g_cnt          <= 2'd0;
      g_bits         <= 2'd0;
      g_fl           <= '0;
      g_fh           <= '0;
      g_nsyms        <= '0;
`endif
    end else begin
      enc_valid <= 1'b0;
      enc_reset <= 1'b0;
      case (state)
        ST_ENC_RST: begin
          enc_reset      <= 1'b1;
          enc_final_flag <= 1'b0;
          first_pend     <= 1'b1;
          last_pend      <= 1'b0;
          state          <= ST_RUN;
        end
        ST_RUN: begin
          if (w_issue) begin
            enc_valid      <= 1'b1;
            enc_flag_first <= first_pend;
            first_pend     <= 1'b0;
            enc_fl         <= w_fl;
            enc_fh         <= w_fh;
            enc_nsyms      <= w_nsyms;
            enc_bool_1     <= w_bool[0];
            enc_bool_2     <= w_bool[1];
            enc_bool_3     <= w_bool[2];
            enc_symbol_1   <= w_sym[0];
            enc_symbol_2   <= w_sym[1];
            enc_symbol_3   <= w_sym[2];
          end
          if (accept && in_last) begin
            last_pend <= 1'b1;
          end
          if (last_pend && drained) begin
            last_pend      <= 1'b0;
            enc_final_flag <= 1'b1;
            state          <= ST_FLUSH;
          end
`ifdef SCHED_BOOL_PACK_EN
          g_cnt   <= g_cnt_nxt;
          g_bits  <= g_bits_nxt;
          g_fl    <= g_fl_nxt;
          g_fh    <= g_fh_nxt;
          g_nsyms <= g_nsyms_nxt;
          if (h_full) begin
            h_full <= 1'b0;
          end else if (h_load) begin
            h_full   <= 1'b1;
            h_fl     <= in_fl;
            h_fh     <= in_fh;
            h_symbol <= in_symbol;
            h_nsyms  <= in_nsyms;
          end
`endif
        end
        ST_FLUSH: begin
          if (enc_flag_last) begin
            enc_final_flag <= 1'b0;
            state          <= ST_ENC_RST;
          end
        end
        default: begin
          state <= ST_ENC_RST;
        end
      endcase
    end
  end

endmodule
